// File: rtl/seq_pkg.sv
// Shared encodings for the 1010 stimulus transmitter and its golden tracker.
package seq_pkg;

  // Transmitter handshake / shift states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  // Tracker progress through the 1010 pattern.
  typedef enum logic [1:0] {
    T0 = 2'd0,  // nothing useful seen
    T1 = 2'd1,  // seen 1
    T2 = 2'd2,  // seen 10
    T3 = 2'd3   // seen 101
  } trk_state_e;

  // Pattern being counted, first-received bit in the MSB.
  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_1010_model.sv
// Overlapping 1010 tracker with a saturating hit counter.
// Usable both inside the transmitter and as a scoreboard model in benches.
module seq_1010_model
  import seq_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] hits
);

  trk_state_e       trk_q, trk_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             hit;

  // A hit is the pattern's final bit arriving while the last three bits already match.
  assign hit = bit_en && (trk_q == T3) && ({PATTERN[3:1], bit_in} == PATTERN);

  // Next tracker state and counter; clr restarts a frame, T3->T2 on 0 keeps the overlap.
  always_comb begin
    trk_d  = trk_q;
    hits_d = hits_q;
    if (clr) begin
      trk_d  = T0;
      hits_d = '0;
    end else if (bit_en) begin
      unique case (trk_q)
        T0:      trk_d = bit_in ? T1 : T0;
        T1:      trk_d = bit_in ? T1 : T2;
        T2:      trk_d = bit_in ? T3 : T0;
        T3:      trk_d = bit_in ? T1 : T2;
        default: trk_d = T0;
      endcase
      if (hit && (hits_q != {CNT_W{1'b1}})) begin
        hits_d = hits_q + CNT_W'(1);
      end
    end
  end

  // Register tracker state and hit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_q  <= T0;
      hits_q <= '0;
    end else begin
      trk_q  <= trk_d;
      hits_q <= hits_d;
    end
  end

  assign hits = hits_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial stimulus transmitter: loads a word via valid/ready, shifts it out
// MSB-first and reports the expected overlapping-1010 count at end of frame.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_len,
  output logic             btn_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exp_hits
);

  localparam logic [CNT_W-1:0] WIDTH_L = CNT_W'(WIDTH);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // bits still to present after the current one
  logic             btn_out_q, btn_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;
  logic [CNT_W-1:0] eff_len;
  logic             accept;

  // Zero or oversize lengths mean a full-width frame.
  assign eff_len = ((load_len == '0) || (load_len > WIDTH_L)) ? WIDTH_L : load_len;
  assign accept  = load_valid && load_ready_q;

  // Next-state and next-output logic; the first bit is presented straight from the accept edge.
  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    btn_out_d    = 1'b0;
    bit_valid_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    load_ready_d = load_ready_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = SHIFT;
          btn_out_d    = load_data[WIDTH-1];
          bit_valid_d  = 1'b1;
          sh_d         = load_data << 1;
          cnt_d        = eff_len - CNT_W'(1);
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          btn_out_d   = sh_q[WIDTH-1];
          bit_valid_d = 1'b1;
          sh_d        = sh_q << 1;
          cnt_d       = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
      end
      default: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        load_ready_d = 1'b1;
      end
    endcase
  end

  // Transmitter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      btn_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      btn_out_q    <= btn_out_d;
      bit_valid_q  <= bit_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Golden tracker watches exactly the bits that leave on btn_out.
  seq_1010_model #(.CNT_W(CNT_W)) u_model (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .bit_en (bit_valid_q),
    .bit_in (btn_out_q),
    .hits   (exp_hits)
  );

  assign load_ready = load_ready_q;
  assign btn_out    = btn_out_q;
  assign bit_valid  = bit_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed frames, random frames, abort and back-to-back loads.
module tb_seq_pattern_tx;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_len;
  logic             btn_out;
  logic             bit_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] exp_hits;

  int n_cmp = 0;
  int n_err = 0;

  seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .btn_out    (btn_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .exp_hits   (exp_hits)
  );

  always #5 clk = ~clk;

  // Reference: effective frame length from the length rule.
  function automatic int ref_len(input int len);
    if (len == 0 || len > WIDTH) return WIDTH;
    return len;
  endfunction

  // Reference: count every (overlapping) window of the sent bits equal to 1,0,1,0.
  function automatic int ref_hits(input logic [WIDTH-1:0] data, input int len);
    int c = 0;
    int b[$];
    for (int i = 0; i < len; i++) b.push_back(int'(data[WIDTH-1-i]));
    for (int i = 0; i + 3 < len; i++)
      if (b[i] == 1 && b[i+1] == 0 && b[i+2] == 1 && b[i+3] == 0) c++;
    return c;
  endfunction

  // Called #1 after the accept edge: checks every bit, the done cycle and the first idle cycle.
  task automatic shift_and_check(input logic [WIDTH-1:0] data, input int len, input string name);
    int exp_h;
    exp_h = ref_hits(data, len);
    for (int i = 0; i < len; i++) begin
      n_cmp++;
      if (bit_valid !== 1'b1 || btn_out !== data[WIDTH-1-i] || busy !== 1'b1 ||
          done !== 1'b0 || load_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s bit%0d: got v=%b b=%b busy=%b done=%b rdy=%b, want v=1 b=%b busy=1 done=0 rdy=0",
                 name, i, bit_valid, btn_out, busy, done, load_ready, data[WIDTH-1-i]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done !== 1'b1 || bit_valid !== 1'b0 || btn_out !== 1'b0 || busy !== 1'b1 ||
        exp_hits !== CNT_W'(exp_h)) begin
      n_err++;
      $display("FAIL %s done-cycle: got done=%b v=%b b=%b busy=%b hits=%0d, want done=1 v=0 b=0 busy=1 hits=%0d",
               name, done, bit_valid, btn_out, busy, exp_hits, exp_h);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bit_valid !== 1'b0 ||
        exp_hits !== CNT_W'(exp_h)) begin
      n_err++;
      $display("FAIL %s idle-after: got rdy=%b busy=%b done=%b v=%b hits=%0d, want rdy=1 busy=0 done=0 v=0 hits=%0d",
               name, load_ready, busy, done, bit_valid, exp_hits, exp_h);
    end
    $display("frame %s data=%h len=%0d hits=%0d (expected %0d)", name, data, len, exp_hits, exp_h);
  endtask

  // Present one word at a negedge and release load_valid right after it is accepted.
  task automatic send_frame(input logic [WIDTH-1:0] data, input int len, input string name);
    @(negedge clk);
    load_data  = data;
    load_len   = CNT_W'(len);
    load_valid = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready-before-load: got %b, want 1", name, load_ready);
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    shift_and_check(data, ref_len(len), name);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (load_ready !== 1'b1 || btn_out !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || exp_hits !== '0) begin
      n_err++;
      $display("FAIL reset: got rdy=%b b=%b v=%b busy=%b done=%b hits=%0d, want rdy=1 rest 0",
               load_ready, btn_out, bit_valid, busy, done, exp_hits);
    end
    $display("reset checked");
  endtask

  task automatic test_directed;
    send_frame(16'hA000, 4,  "a000_len4");
    send_frame(16'hAAAA, 0,  "aaaa_len0");
    send_frame(16'hD000, 6,  "d000_len6");
    send_frame(16'hF000, 20, "f000_len20");
    send_frame(16'h8000, 1,  "8000_len1");
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      logic [WIDTH-1:0] d;
      int len;
      // Bias toward 1010-rich words so hit counts are non-trivial.
      d   = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom) : (WIDTH'($urandom) | 16'hA5A5) & ~16'h4242;
      len = $urandom_range(0, (1 << CNT_W) - 1);
      send_frame(d, len, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    load_data  = 16'hAAAA;
    load_len   = '0;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (bit_valid !== 1'b1 || btn_out !== load_data[WIDTH-1-i]) begin
        n_err++;
        $display("FAIL abort bit%0d: got v=%b b=%b, want v=1 b=%b", i, bit_valid, btn_out, load_data[WIDTH-1-i]);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b1 || btn_out !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || exp_hits !== '0) begin
      n_err++;
      $display("FAIL abort-reset: got rdy=%b b=%b v=%b busy=%b done=%b hits=%0d, want rdy=1 rest 0",
               load_ready, btn_out, bit_valid, busy, done, exp_hits);
    end
    $display("abort checked");
    send_frame(16'hA000, 4, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] w1, w2;
    w1 = 16'hB500;
    w2 = 16'h5A5A;
    @(negedge clk);
    load_data  = w1;
    load_len   = CNT_W'(8);
    load_valid = 1'b1;
    @(posedge clk); #1;
    // Second word waits on the bus with load_valid still high.
    load_data = w2;
    load_len  = CNT_W'(12);
    shift_and_check(w1, 8, "b2b_first");
    @(posedge clk); #1;
    load_valid = 1'b0;
    shift_and_check(w2, 12, "b2b_second");
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial stimulus transmitter for the 1010 overlapping Mealy detector path. It accepts a parallel word through a valid/ready load handshake and shifts it out MSB-first, one bit per clock, on the detector's serial input line. In parallel it runs a golden overlapping-1010 tracker on the transmitted bits. It reports the expected detection count at end of frame, so the detector can be checked in loopback.

Parameters:
WIDTH, 16, maximum frame length in bits; the load word width.
CNT_W, 5, width of the length field and of the hit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
load_valid  input  1  load request.
load_ready  output  1  high only in IDLE; the transfer occurs when load_valid && load_ready at a rising edge.
load_data  input  WIDTH  frame bits; bit WIDTH-1 is sent first.
load_len  input  CNT_W  number of bits to send, taken from the MSB downward.
btn_out  output  1  serial bit to the detector; 0 when bit_valid=0.
bit_valid  output  1  high for each cycle that btn_out carries a frame bit.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse at end of frame.
exp_hits  output  CNT_W  count of overlapping 1010 occurrences in the frame; final value is valid while done=1 and held until the next accept.

Behaviour:
- All outputs are registered.
- Reset (any state, including mid-frame) forces:
  - state IDLE, load_ready=1.
  - btn_out=0, bit_valid=0, busy=0, done=0.
  - exp_hits=0, tracker in T0.
- Length rule: load_len=0 or load_len>WIDTH is treated as WIDTH. The effective length L is latched at accept.
- States (encoded in the package):
  - IDLE: load_ready=1. On accept, latch load_data into the shift register and latch L. Clear exp_hits and the tracker. Go to SHIFT.
  - SHIFT: with accept at edge k, cycles k+1..k+L present frame bit i on btn_out with bit_valid=1. The register shifts left each cycle. After the L-th bit, go to DONE.
  - DONE: one cycle (k+L+1). done=1, bit_valid=0, btn_out=0, busy=1, exp_hits final. Then go to IDLE; load_ready=1 from cycle k+L+2.
- load_valid is ignored while busy; no queuing. A load_valid held high continuously is accepted in the first IDLE cycle after DONE.
- Tracker states, advanced once per transmitted bit (next state, 1 / 0):
  - T0 (none): T1 / T0.
  - T1 (seen 1): T1 / T2.
  - T2 (seen 10): T3 / T0.
  - T3 (seen 101): T1 / T2, plus a hit on 0.
  - On a hit, exp_hits increments (saturating at 2^CNT_W-1).
  - The T3 -> T2 transition on 0 gives overlap: 1010 followed by 10 counts again.
- exp_hits updates in the same cycle as the bit that completes the pattern. It is visible one cycle later, and no later than the DONE cycle.
- The tracker does not carry across frames; each frame is counted independently.

Decomposition:
- Package seq_pkg holds:
  - Transmitter state encodings: IDLE, SHIFT, DONE.
  - Tracker state encodings: T0..T3.
  - Constant PATTERN = 4'b1010.
- Sub-module seq_1010_model holds the tracker plus hit counter.
  - Inputs: clk, rst, clr, bit_en, bit_in.
  - Output: hits[CNT_W-1:0].
  - It is reusable as a scoreboard model in benches.
- The top module holds the handshake FSM, the shift register and the length counter.

Test Plan:
- Reset and idle: assert rst for 2 cycles, then idle -> load_ready=1; btn_out, bit_valid, busy, done and exp_hits all 0.
- load_data=16'hA000, load_len=4, accepted at edge k:
  - Cycles k+1..k+4: btn_out=1,0,1,0 with bit_valid=1.
  - Cycle k+5: done=1, exp_hits=1.
  - Cycle k+6: load_ready=1.
- load_data=16'hAAAA, load_len=0 -> 16 bits 1010...10 sent; done at k+17 with exp_hits=7 (overlap counted).
- load_data=16'hD000, load_len=6 (bits 110100) -> exp_hits=1.
- load_data=16'hF000, load_len=20 (clamped to 16) -> exp_hits=0.
- rst asserted after the 3rd bit of a 16-bit frame -> next cycle all outputs 0, load_ready=1.
  - A new load of 16'hA000, load_len=4 then gives exp_hits=1; no residue from the aborted frame.
- load_valid held high with two different words -> second word accepted exactly one cycle after the first frame's done pulse; no bit of the second word appears during the first frame.
